// File: rtl/console_pkg.sv
// Shared definitions for the memory-mapped console transmitter:
// UART FSM states, default bus addresses and status word layout.
package console_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam logic [31:0] DEF_TX_ADDR     = 32'h0000_0400;
    localparam logic [31:0] DEF_STATUS_ADDR = 32'h0000_0404;

    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;

    function automatic logic [31:0] status_word(input logic ovf, input logic busy,
                                                input logic empty, input logic full);
        logic [31:0] w;
        w = 32'h0;
        w[STAT_OVF]   = ovf;
        w[STAT_BUSY]  = busy;
        w[STAT_EMPTY] = empty;
        w[STAT_FULL]  = full;
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; pushes while full and pops while
// empty are ignored, pointers wrap naturally because DEPTH is a power of two.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      count_q;
    logic             do_push, do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == (PW+1)'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/mmio_console_tx.sv
// Console transmitter on the data-memory bus: byte stores to TX_ADDR are queued
// and sent as 8N1 UART frames; a combinational status word is offered at STATUS_ADDR.
module mmio_console_tx
    import console_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 16,
    parameter logic [31:0] TX_ADDR      = DEF_TX_ADDR,
    parameter logic [31:0] STATUS_ADDR  = DEF_STATUS_ADDR
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic        StatusHit,
    output logic [31:0] StatusData,
    output logic        tx
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_e   state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]  bit_q;
    logic [7:0]  shift_q;
    logic        tx_q;
    logic        ovf_q, ovf_d;

    logic        push_req, clr_req, pop;
    logic        fifo_full, fifo_empty;
    logic [7:0]  fifo_dout;
    logic [CW-1:0] fifo_count;
    logic        baud_last;
    logic        unused_wdata;

    assign unused_wdata = ^WriteData[31:8];

    assign push_req  = MemWrite && (DataAdr == TX_ADDR);
    assign clr_req   = MemWrite && (DataAdr == STATUS_ADDR);
    assign baud_last = (baud_q == BAUD_LAST);
    assign pop       = !fifo_empty && ((state_q == ST_IDLE) ||
                                       (state_q == ST_STOP && baud_last));

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK   (CLK),
        .reset (reset),
        .push  (push_req),
        .din   (WriteData[7:0]),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A dropped store outranks a clear landing on the same edge.
    always_comb begin
        ovf_d = ovf_q;
        if (push_req && (fifo_count == CW'(FIFO_DEPTH))) ovf_d = 1'b1;
        else if (clr_req)                                ovf_d = 1'b0;
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tx_q   <= 1'b1;
                    baud_q <= '0;
                    if (pop) begin
                        shift_q <= fifo_dout;
                        state_q <= ST_START;
                        tx_q    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        state_q <= ST_DATA;
                        tx_q    <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            state_q <= ST_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= {1'b0, shift_q[7:1]};
                            tx_q    <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (pop) begin
                            shift_q <= fifo_dout;
                            state_q <= ST_START;
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= ST_IDLE;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign tx         = tx_q;
    assign StatusHit  = (DataAdr == STATUS_ADDR);
    assign StatusData = status_word(ovf_q, state_q != ST_IDLE, fifo_empty, fifo_full);

endmodule

// File: tb/tb_mmio_console_tx.sv
// Bench for mmio_console_tx: random bus stores against a queue-level model of
// the FIFO and transmitter; a UART monitor decodes frames and checks them in order.
module tb_mmio_console_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;
  localparam logic [31:0] A_TX = 32'h0000_0400;
  localparam logic [31:0] A_ST = 32'h0000_0404;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] data_adr = 32'h0;
  logic [31:0] write_data = 32'h0;
  logic        status_hit;
  logic [31:0] status_data;
  logic        tx;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // model state
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  int         exp_t_q[$];
  int         m_edge = 0;
  int         free_at = 0;
  logic       m_ovf = 1'b0;

  mmio_console_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH),
    .TX_ADDR(A_TX),
    .STATUS_ADDR(A_ST)
  ) dut (
    .CLK(clk),
    .reset(rst_n),
    .MemWrite(mem_write),
    .DataAdr(data_adr),
    .WriteData(write_data),
    .StatusHit(status_hit),
    .StatusData(status_data),
    .tx(tx)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a byte queue plus the edge at which the line frees up.
  task automatic model_edge(input logic we, input logic [31:0] adr, input logic [31:0] data);
    int pre;
    m_edge++;
    if (!rst_n) begin
      mq.delete();
      free_at = 0;
      m_ovf = 1'b0;
      return;
    end
    pre = mq.size();
    if (we && adr == A_TX && pre >= DEPTH) m_ovf = 1'b1;
    else if (we && adr == A_ST) m_ovf = 1'b0;
    if (pre > 0 && m_edge >= free_at) begin
      exp_q.push_back(mq.pop_front());
      exp_t_q.push_back(m_edge);
      free_at = m_edge + FRAME;
    end
    if (we && adr == A_TX && pre < DEPTH) mq.push_back(data[7:0]);
  endtask

  function automatic logic [31:0] model_status();
    return {28'h0, m_ovf, (m_edge < free_at), (mq.size() == 0), (mq.size() == DEPTH)};
  endfunction

  // driver tasks
  task automatic step(input logic we, input logic [31:0] adr, input logic [31:0] data);
    mem_write = we;
    data_adr = adr;
    write_data = data;
    @(posedge clk);
    model_edge(we, adr, data);
    #1;
    chk("status_data", status_data, model_status());
    chk("status_hit", {31'h0, status_hit}, {31'h0, (adr == A_ST)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, $urandom);
  endtask

  task automatic store(input logic [31:0] adr, input logic [7:0] b);
    step(1'b1, adr, {$urandom_range(0, 255), 16'h0, b} & 32'hFFFF_FFFF);
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    mq.delete();
    exp_q.delete();
    exp_t_q.delete();
    free_at = 0;
    m_ovf = 1'b0;
    #1;
    chk("tx_async_reset", {31'h0, tx}, 32'h1);
    chk("status_async_reset", status_data, 32'h2);
  endtask

  task automatic drain();
    int guard = 0;
    while ((mq.size() > 0 || m_edge < free_at || exp_q.size() > 0) && guard < 2000) begin
      idle(1);
      guard++;
    end
    chk("drain_timeout", guard, (guard < 2000) ? guard : 0);
    idle(3);
    chk("exp_q_empty", exp_q.size(), 0);
  endtask

  // UART monitor: collects 10*CPB samples per frame and checks shape, data, start time
  logic s_bits [FRAME];
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && tx == 1'b0) begin
        int   t0;
        logic aborted;
        logic shape_ok;
        logic [7:0] b;
        t0 = cyc;
        aborted = 1'b0;
        s_bits[0] = 1'b0;
        for (int i = 1; i < FRAME; i++) begin
          @(negedge clk);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          s_bits[i] = tx;
        end
        if (!aborted) begin
          shape_ok = (s_bits[FRAME-1] == 1'b1);
          for (int k = 0; k < 10; k++)
            for (int j = 1; j < CPB; j++)
              if (s_bits[k*CPB + j] !== s_bits[k*CPB]) shape_ok = 1'b0;
          b = '0;
          for (int k = 0; k < 8; k++) b[k] = s_bits[(k+1)*CPB];
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", {24'h0, b}, 32'hFFFF_FFFF);
          end else begin
            logic [7:0] eb;
            int et;
            eb = exp_q.pop_front();
            et = exp_t_q.pop_front();
            chk("frame_byte", {24'h0, b}, {24'h0, eb});
            chk("frame_start_cycle", t0, et);
            chk("frame_shape", {31'h0, shape_ok}, 32'h1);
          end
        end
      end
    end
  end

  // stimulus
  initial begin
    idle(3);
    chk("reset_tx", {31'h0, tx}, 32'h1);
    rst_n = 1'b1;
    idle(2);

    // single byte
    store(A_TX, 8'h55);
    drain();
    chk("single_status_after", status_data, 32'h2);

    // back-to-back
    store(A_TX, 8'hA1);
    store(A_TX, 8'h3C);
    drain();

    // overflow: six consecutive stores, then clear
    for (int i = 0; i < 6; i++) store(A_TX, 8'($urandom_range(0, 255)));
    chk("ovf_full_set", status_data & 32'h9, 32'h9);
    idle(5);
    store(A_ST, 8'h00);
    chk("ovf_cleared", status_data & 32'h8, 32'h0);
    drain();

    // decode filter
    store(32'h0000_0408, 8'h77);
    step(1'b0, A_TX, 32'h0000_00EE);
    step(1'b0, A_ST, 32'h0000_00EE);
    step(1'b1, 32'h0000_0000, 32'h0000_0012);
    idle(5);
    chk("filter_no_push", status_data, 32'h2);

    // reset during DATA bit 3 with two bytes queued
    store(A_TX, 8'hC3);
    store(A_TX, 8'h5A);
    store(A_TX, 8'h0F);
    idle(16);
    assert_reset();
    idle(2);
    rst_n = 1'b1;
    idle(60);
    chk("post_reset_quiet", status_data, 32'h2);

    // wrap-around: 10 bytes in bursts of three
    for (int v = 0; v < 10; v += 3) begin
      for (int k = v; k < v + 3 && k < 10; k++) store(A_TX, 8'(k));
      drain();
    end

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 15);
      if (r < 3)       store(A_TX, 8'($urandom_range(0, 255)));
      else if (r == 3) store(A_ST, 8'($urandom_range(0, 255)));
      else if (r == 4) store(32'h0000_0408, 8'($urandom_range(0, 255)));
      else if (r == 5) step(1'b0, A_ST, $urandom);
      else             idle(1);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mmio_console_tx.md
# mmio_console_tx

Memory-mapped console transmitter on the processor's data-memory bus. Captures byte stores from the processor (`MemWrite`/`DataAdr`/`WriteData`) to a TX register, buffers them in a FIFO, and serializes them on a UART line as 8N1 frames, LSB first. Exposes a read-only status word, muxed by the data-memory read path, so firmware can poll before writing.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200); legal range ≥ 2.
- `FIFO_DEPTH`, 16: byte entries; power of two, ≥ 2.
- `TX_ADDR`, 32'h0000_0400: store target for transmit data.
- `STATUS_ADDR`, 32'h0000_0404: status read address; stores here clear overflow.
- `CLK`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `MemWrite`  in  1  processor store strobe.
- `DataAdr`  in  32  processor data address.
- `WriteData`  in  32  processor store data; only [7:0] used.
- `StatusHit`  out  1  combinational; 1 when `DataAdr == STATUS_ADDR`.
- `StatusData`  out  32  combinational; {28'b0, overflow, busy, empty, full}.
- `tx`  out  1  UART serial output, idle high, registered.

## Operation
- Push: at a rising edge with `MemWrite=1` and `DataAdr==TX_ADDR`, `WriteData[7:0]` enters the FIFO if the pre-edge count < `FIFO_DEPTH`.
- Store while full: byte dropped, sticky `overflow` set. This applies even if a pop occurs on the same edge; fullness is judged on pre-edge state.
- Store to `STATUS_ADDR`: clears `overflow`. If a dropped push sets `overflow` on the same edge as the clear, set wins.
- Other addresses are ignored.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx=1`. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: `tx=0` for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `tx=shift[0]` for `CLKS_PER_BIT` cycles per bit, shifting right. After bit 7, go to STOP.
  - STOP: `tx=1` for `CLKS_PER_BIT` cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter: counts 0..`CLKS_PER_BIT-1` and resets on every state or bit change. Width is `$clog2(CLKS_PER_BIT)`.
- Status bits:
  - `busy` = state != IDLE.
  - `empty` = count == 0.
  - `full` = count == `FIFO_DEPTH`.
- FIFO pointers wrap modulo `FIFO_DEPTH`. Count width is `$clog2(FIFO_DEPTH)+1`.

## Timing
- Reset values (asserted asynchronously, mid-frame included):
  - `tx=1` immediately.
  - State IDLE, FIFO emptied, `overflow=0`, counters 0.
  - Resulting `StatusData=32'h2`.
  - The in-flight frame is truncated, not completed.
- Push at edge N: `empty` falls after edge N. The FSM pops at edge N+1, and `tx` falls after edge N+1.
- Frame length: exactly `10*CLKS_PER_BIT` cycles from `tx` falling to the end of STOP.
- Back-to-back bytes: the next start bit begins on the cycle after the last STOP cycle.
- FIFO count changes by −1, 0 or +1 per edge. A simultaneous push and pop with count in (0, DEPTH) leaves the count unchanged.
- `StatusHit`/`StatusData` are purely combinational, with zero-cycle latency from `DataAdr` and the registered flags.

## Structure
- Package `console_pkg`:
  - state enum/localparams (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3)
  - default `TX_ADDR` and `STATUS_ADDR`
  - status bit positions
- Sub-module `sync_fifo` (params WIDTH=8, DEPTH):
  - ports CLK, reset, push, din, pop, dout, count, full, empty
  - first-word-fall-through
  - same reset convention
- Top level holds address decode, the overflow flag, the baud counter, and the UART FSM.

## Test plan
(`CLKS_PER_BIT=4`, `FIFO_DEPTH=4`)
- Single byte: store 32'h0000_0055 to 32'h400. `tx` sequence, 4 cycles each: 0, 1,0,1,0,1,0,1,0, 1. Frame is 40 cycles. `busy` returns to 0 and `StatusData=32'h2`.
- Back-to-back: store 8'hA1 then 8'h3C on consecutive cycles. Two frames decode as A1 then 3C with no idle cycle between STOP and the second START.
- Overflow: six stores on consecutive cycles during the first frame.
  - 5 bytes accepted: one popped immediately, then 4 fill the FIFO.
  - Store 6 is dropped; `full=1` and `overflow=1` (`StatusData[3]`).
  - A store to 32'h404 clears bit 3.
- Decode filter: stores to 32'h408 and reads without `MemWrite` to 32'h400 cause no push. `StatusHit=1` only when `DataAdr=32'h404`.
- Reset mid-frame: assert `reset=0` during DATA bit 3 with 2 bytes queued. `tx=1` within the same cycle and `StatusData=32'h2`. After release, no frame is emitted until a new store.
- Wrap-around: push and transmit 10 bytes (0x00..0x09) in bursts of 3. All decode in order across pointer wrap.
